alu_issue_stage: RTL and testbench

//  Operand-issue and result-capture stage wrapped around the combinational 16-bit ALU.

---
 rtl/alu_issue_stage.sv | 148 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: request FIFO + operand issue + registered result port
// wrapped around an external combinational ALU. The FIFO head is driven onto
// the ALU inputs; the ALU output is captured into a valid/ready result
// register. carry_reg holds the last issued carry_out so that multi-word
// add/sub can be expressed as back-to-back chained 16-bit operations.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload stable while valid && !ready. in_ready
// depends only on registered occupancy, so it has no path from in_valid.
// out_* are registers and stay stable while out_valid && !out_ready.
module alu_issue_stage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   // request port
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_mode,
   input  logic [3:0]                 in_select,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic                       in_carry,
   input  logic                       in_chain,
   // ALU drive
   output logic                       alu_mode,
   output logic [3:0]                 alu_select,
   output logic [WIDTH-1:0]           alu_a,
   output logic [WIDTH-1:0]           alu_b,
   output logic                       alu_carry_in,
   // ALU return
   input  logic [WIDTH-1:0]           alu_result,
   input  logic                       alu_carry_out,
   // result port
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_result,
   output logic                       out_carry,
   output logic                       out_zero,
   // status
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // One queued operation exactly as presented on the request port.
   typedef struct packed {
      logic             mode;
      logic [3:0]       select;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             carry;
      logic             chain;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             carry_reg;
   logic             push;
   logic             issue;
   logic             drain;

   // No bypass: a full FIFO refuses input even if the head pops this cycle.
   assign in_ready   = (count < CW'(DEPTH));
   assign push       = in_valid && in_ready;
   // Issue whenever something is queued and the result register is free or
   // being emptied this cycle.
   assign issue      = (count != '0) && (!out_valid || out_ready);
   // Result consumed with nothing behind it: the result register goes idle.
   assign drain      = out_valid && out_ready && (count == '0);
   assign fifo_count = count;

   // Head entry straight from storage; when empty this is a stale entry and
   // the ALU output is ignored because no issue can happen.
   assign head         = mem[rd_ptr];
   assign alu_mode     = head.mode;
   assign alu_select   = head.select;
   assign alu_a        = head.a;
   assign alu_b        = head.b;
   assign alu_carry_in = head.chain ? carry_reg : head.carry;

   // FIFO storage: payload only, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= '{mode:   in_mode,
                          select: in_select,
                          a:      in_a,
                          b:      in_b,
                          carry:  in_carry,
                          chain:  in_chain};
      end
   end

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, issue})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Result register and chaining carry: capture ALU output on issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_carry  <= 1'b0;
         out_zero   <= 1'b0;
         carry_reg  <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         carry_reg  <= 1'b0;
      end else if (issue) begin
         out_valid  <= 1'b1;
         out_result <= alu_result;
         out_carry  <= alu_carry_out;
         out_zero   <= (alu_result == '0);
         // Logic-mode ops return carry_out=0 and still clear the chain carry.
         carry_reg  <= alu_carry_out;
      end else if (drain) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU on the alu_* loop, a scoreboard
// fed at request acceptance, and a monitor that checks every consumed result.
module tb_alu_issue_stage;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int EW    = WIDTH + 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_mode = 1'b0;
   logic [3:0]        in_select = 4'h0;
   logic [WIDTH-1:0]  in_a = '0;
   logic [WIDTH-1:0]  in_b = '0;
   logic              in_carry = 1'b0;
   logic              in_chain = 1'b0;
   logic              alu_mode;
   logic [3:0]        alu_select;
   logic [WIDTH-1:0]  alu_a;
   logic [WIDTH-1:0]  alu_b;
   logic              alu_carry_in;
   logic [WIDTH-1:0]  alu_result;
   logic              alu_carry_out;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WIDTH-1:0]  out_result;
   logic              out_carry;
   logic              out_zero;
   logic [CW-1:0]     fifo_count;

   int tests = 0;
   int fails = 0;
   logic [EW-1:0] exp_q[$];
   logic          model_carry = 1'b0;
   logic          rand_ready = 1'b0;

   alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_select(in_select), .in_a(in_a), .in_b(in_b),
      .in_carry(in_carry), .in_chain(in_chain),
      .alu_mode(alu_mode), .alu_select(alu_select), .alu_a(alu_a),
      .alu_b(alu_b), .alu_carry_in(alu_carry_in),
      .alu_result(alu_result), .alu_carry_out(alu_carry_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carry(out_carry), .out_zero(out_zero), .fifo_count(fifo_count)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural ALU: returns {carry_out, result} ----------
   function automatic logic [WIDTH:0] alu_f(input logic mode, input logic [3:0] sel,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic cin);
      logic [WIDTH:0] ea, eb, ec;
      ea = {1'b0, a};
      eb = {1'b0, b};
      ec = (WIDTH+1)'(cin);
      if (mode) begin
         case (sel)
            4'b0000: return {1'b0, ~a};
            4'b0110: return {1'b0, a ^ b};
            4'b1011: return {1'b0, a & b};
            4'b1110: return {1'b0, a | b};
            default: return {1'b0, ~(a ^ b)};
         endcase
      end
      case (sel)
         4'b0110: return ea + {1'b0, ~b} + ec;
         4'b0000: return ea + ec;
         4'b1100: return ea + ea + ec;
         default: return ea + eb + ec;
      endcase
   endfunction

   logic [WIDTH:0] alu_full;
   always_comb begin
      alu_full      = alu_f(alu_mode, alu_select, alu_a, alu_b, alu_carry_in);
      alu_result    = alu_full[WIDTH-1:0];
      alu_carry_out = alu_full[WIDTH];
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: stage is an in-order queue ----------
   // Results come out in acceptance order; a chained op sees the carry of the
   // previous surviving op, and flush/reset forget everything.
   task automatic model_accept(input logic mode, input logic [3:0] sel,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic chain);
      logic [WIDTH:0] r;
      r = alu_f(mode, sel, a, b, chain ? model_carry : cin);
      model_carry = r[WIDTH];
      exp_q.push_back({(r[WIDTH-1:0] == '0), r[WIDTH], r[WIDTH-1:0]});
   endtask

   task automatic model_clear();
      exp_q.delete();
      model_carry = 1'b0;
   endtask

   // ---------------- driver tasks (start and end at posedge + 1) ----------
   task automatic push_op(input logic mode, input logic [3:0] sel,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic chain);
      int waited = 0;
      in_valid = 1'b1; in_mode = mode; in_select = sel;
      in_a = a; in_b = b; in_carry = cin; in_chain = chain;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL push_timeout: in_ready stuck at 0, required 1");
         @(posedge clk); #1 in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_accept(mode, sel, a, b, cin, chain);
      #1 in_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk);
      model_clear();
      #1 flush = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: got %0h with nothing expected", out_result);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("result", 32'(out_result), 32'(e[WIDTH-1:0]));
            check("carry",  32'(out_carry),  32'(e[WIDTH]));
            check("zero",   32'(out_zero),   32'(e[WIDTH+1]));
         end
      end
   end

   // Random consumer backpressure during the random phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      // reset values while held in reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_result", 32'(out_result), 32'd0);
      check("rst_carry", 32'(out_carry), 32'd0);
      check("rst_zero", 32'(out_zero), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // single add with latency check
      out_ready = 1'b1;
      push_op(1'b0, 4'b1001, 16'h1234, 16'h0001, 1'b0, 1'b0);
      @(negedge clk);
      check("lat_valid_k", 32'(out_valid), 32'd0);
      check("lat_count_k", 32'(fifo_count), 32'd1);
      @(negedge clk);
      check("lat_valid_k1", 32'(out_valid), 32'd1);
      check("add_result", 32'(out_result), 32'h1235);
      check("add_carry", 32'(out_carry), 32'd0);
      check("add_zero", 32'(out_zero), 32'd0);
      drain();

      // chained 32-bit add
      push_op(1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      push_op(1'b0, 4'b1001, 16'h0000, 16'h0000, 1'b0, 1'b1);
      @(negedge clk);
      check("chain1_result", 32'(out_result), 32'h0000);
      check("chain1_carry", 32'(out_carry), 32'd1);
      check("chain1_zero", 32'(out_zero), 32'd1);
      @(negedge clk);
      check("chain2_result", 32'(out_result), 32'h0001);
      check("chain2_carry", 32'(out_carry), 32'd0);
      drain();

      // backpressure to full
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_op(1'b0, 4'b1001, 16'(i * 16'h1111), 16'(i + 3), 1'(i & 1), 1'b0);
      @(negedge clk);
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      drain();

      // simultaneous push + issue at count 2
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push_op(1'b1, 4'b0110, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      check("pp_count_setup", 32'(fifo_count), 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_op(1'b0, 4'b0110, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
         check("pp_count", 32'(fifo_count), 32'd2);
      end
      drain();

      // flush with 3 queued and a held result; carry_reg left at 1 first
      out_ready = 1'b0;
      push_op(1'b0, 4'b1001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         push_op(1'b0, 4'b1001, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      check("pre_flush_count", 32'(fifo_count), 32'd3);
      do_flush();
      check("flush_count", 32'(fifo_count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      push_op(1'b0, 4'b1001, 16'h0000, 16'h0000, 1'b1, 1'b1);
      @(negedge clk);
      check("flush_chain_cin", 32'(alu_carry_in), 32'd0);
      drain();

      // reset mid-stream
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push_op(1'b0, 4'b1001, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_count", 32'(fifo_count), 32'd0);
      model_clear();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_valid_after", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      // randomized traffic with backpressure and occasional flushes
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [3:0]       sel;
         logic [WIDTH-1:0] a, b;
         case ($urandom_range(0, 4))
            0: sel = 4'b1001;
            1: sel = 4'b0110;
            2: sel = 4'b0000;
            3: sel = 4'b1100;
            default: sel = 4'($urandom);
         endcase
         a = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
         b = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
         if ($urandom_range(0, 39) == 0) do_flush();
         push_op(1'($urandom_range(0, 3) == 0), sel, a, b,
                 1'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk); #1;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
